mips_muldiv_seq: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit with HI/LO registers for the MIPS datapath.

---
 rtl/mips_muldiv_seq.sv | 122 ++++++++++++
 tb/tb_mips_muldiv_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv_seq.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers and MTHI/MTLO writes.
// One shared 2*WIDTH accumulator serves both the shift-add multiplier and the restoring divider.
module mips_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi_reg,
    output logic [WIDTH-1:0] lo_reg
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;      // MUL: {partial, multiplier}; DIV: {remainder, quotient}
    logic [WIDTH-1:0]   opnd;     // multiplicand or divisor magnitude
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               dbz;

    // Operand magnitudes for signed ops (op[0]==0 selects signed)
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_neg = ~op[0] & operand_a[WIDTH-1];
    assign b_neg = ~op[0] & operand_b[WIDTH-1];
    assign a_mag = a_neg ? -operand_a : operand_a;
    assign b_mag = b_neg ? -operand_b : operand_b;

    // Shift-add step: add multiplicand into upper half when multiplier LSB set, then shift right
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Restoring step: shift in next dividend bit, keep difference only when it does not borrow
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   diff;
    logic               no_borrow;
    logic [2*WIDTH-1:0] div_next;
    assign rem_sh    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign diff      = {1'b0, rem_sh} - {2'b00, opnd};
    assign no_borrow = ~diff[WIDTH+1];
    assign div_next  = {(no_borrow ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], no_borrow};

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    assign prod_fix = neg_q ? -acc : acc;
    assign quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            opnd        <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dbz         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op <= 3'd3) begin
                            acc    <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                            opnd   <= op[1] ? b_mag : a_mag;
                            is_div <= op[1];
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= a_neg;
                            dbz    <= op[1] & (operand_b == '0);
                            cnt    <= CNT_W'(WIDTH);
                            busy   <= 1'b1;
                            state  <= CALC;
                        end else if (op == 3'd4) begin
                            hi_reg <= operand_a;
                        end else if (op == 3'd5) begin
                            lo_reg <= operand_a;
                        end
                    end
                end
                CALC: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1))
                        state <= FIX;
                end
                FIX: begin
                    // Divide by zero: quotient all ones; remainder sign-fix already restores the dividend
                    if (is_div) begin
                        lo_reg <= dbz ? {WIDTH{1'b1}} : quo_fix;
                        hi_reg <= rem_fix;
                    end else begin
                        {hi_reg, lo_reg} <= prod_fix;
                    end
                    done        <= 1'b1;
                    div_by_zero <= dbz;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_muldiv_seq.sv
// Randomized bench for mips_muldiv_seq (WIDTH=32 and WIDTH=8) against a plain-arithmetic model.
module tb_mips_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start32 = 1'b0, start8 = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] opa = '0, opb = '0;
    logic        busy32, done32, dbz32, busy8, done8, dbz8;
    logic [31:0] hi32, lo32;
    logic [7:0]  hi8, lo8;

    int errs = 0, checks = 0;
    logic [31:0] m_hi32 = '0, m_lo32 = '0, m_hi8 = '0, m_lo8 = '0;

    always #5 clk = ~clk;

    mips_muldiv_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .op(op), .operand_a(opa), .operand_b(opb),
        .busy(busy32), .done(done32), .div_by_zero(dbz32), .hi_reg(hi32), .lo_reg(lo32));

    mips_muldiv_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op), .operand_a(opa[7:0]), .operand_b(opb[7:0]),
        .busy(busy8), .done(done8), .div_by_zero(dbz8), .hi_reg(hi8), .lo_reg(lo8));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] g_hi(int w); return (w == 8) ? {24'h0, hi8} : hi32; endfunction
    function automatic logic [31:0] g_lo(int w); return (w == 8) ? {24'h0, lo8} : lo32; endfunction
    function automatic logic g_done(int w); return (w == 8) ? done8 : done32; endfunction
    function automatic logic g_busy(int w); return (w == 8) ? busy8 : busy32; endfunction
    function automatic logic g_dbz(int w);  return (w == 8) ? dbz8 : dbz32; endfunction

    // Reference: MIPS MULT/DIV semantics in w-bit two's complement using 64-bit arithmetic
    function automatic void model(input int w, input logic [2:0] o, input logic [31:0] a, b,
                                  output logic [31:0] hi, output logic [31:0] lo, output bit z);
        longint unsigned mask = (64'd1 << w) - 1;
        longint unsigned ua = longint'(a) & mask, ub = longint'(b) & mask, p;
        longint sa = longint'(ua), sb = longint'(ub), q, r;
        if (((ua >> (w - 1)) & 1) == 1) sa = sa - longint'(64'd1 << w);
        if (((ub >> (w - 1)) & 1) == 1) sb = sb - longint'(64'd1 << w);
        z = 1'b0; hi = '0; lo = '0; p = '0;
        if (o <= 3'd1) begin
            p  = (o == 3'd0) ? longint'(sa * sb) : ua * ub;
            hi = 32'((p >> w) & mask);
            lo = 32'(p & mask);
        end else if (ub == 0) begin
            lo = 32'(mask); hi = 32'(ua); z = 1'b1;
        end else if (o == 3'd2) begin
            if (sa == -longint'(64'd1 << (w - 1)) && sb == -1) begin
                lo = 32'(ua); hi = '0;
            end else begin
                q = sa / sb; r = sa % sb;
                lo = 32'(q) & 32'(mask); hi = 32'(r) & 32'(mask);
            end
        end else begin
            lo = 32'(ua / ub); hi = 32'(ua % ub);
        end
    endfunction

    task automatic set_start(input int w, input logic v);
        if (w == 8) start8 = v; else start32 = v;
    endtask

    task automatic run_op(input int w, input logic [2:0] o, input logic [31:0] a, b, input bit inj);
        logic [31:0] eh, el, ph, pl;
        bit ez;
        int n, extra;
        model(w, o, a, b, eh, el, ez);
        ph = (w == 8) ? m_hi8 : m_hi32;
        pl = (w == 8) ? m_lo8 : m_lo32;
        op = o; opa = a; opb = b;
        set_start(w, 1'b1);
        @(posedge clk); #1;
        set_start(w, 1'b0);
        op = 3'($urandom); opa = $urandom; opb = $urandom;
        if (o >= 3'd4) begin
            if (o == 3'd4) ph = (w == 8) ? (a & 32'hFF) : a;
            if (o == 3'd5) pl = (w == 8) ? (a & 32'hFF) : a;
            chk("mt_hi", g_hi(w), ph);
            chk("mt_lo", g_lo(w), pl);
            chk("mt_done", g_done(w), 1'b0);
            chk("mt_busy", g_busy(w), 1'b0);
        end else begin
            chk("busy_after_start", g_busy(w), 1'b1);
            chk("hi_held_busy", g_hi(w), ph);
            n = 0;
            while (!g_done(w) && n < 200) begin
                if (inj && n == 4) begin op = 3'd2; set_start(w, 1'b1); end
                @(posedge clk); #1;
                set_start(w, 1'b0);
                n++;
            end
            chk("latency", n, w + 1);
            chk("res_hi", g_hi(w), eh);
            chk("res_lo", g_lo(w), el);
            chk("dbz", g_dbz(w), ez);
            chk("busy_at_done", g_busy(w), 1'b0);
            ph = eh; pl = el;
            @(posedge clk); #1;
            chk("done_one_cycle", g_done(w), 1'b0);
            chk("dbz_one_cycle", g_dbz(w), 1'b0);
            if (inj) begin
                extra = 0;
                repeat (w + 4) begin @(posedge clk); #1; if (g_done(w)) extra++; end
                chk("ignored_start_no_done", extra, 0);
            end
        end
        if (w == 8) begin m_hi8 = ph; m_lo8 = pl; end
        else begin m_hi32 = ph; m_lo32 = pl; end
    endtask

    initial begin
        logic [31:0] a, b;
        logic [2:0]  o;
        int r, nd;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_busy", busy32, 1'b0);
        chk("rst_done", done32, 1'b0);
        chk("rst_hi", hi32, 32'h0);
        chk("rst_lo", lo32, 32'h0);

        run_op(32, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op(32, 3'd0, 32'hFFFFFFFD, 32'd7, 1'b0);
        run_op(32, 3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
        run_op(32, 3'd3, 32'd100, 32'd0, 1'b0);
        run_op(32, 3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        run_op(32, 3'd4, 32'h1234, 32'h0, 1'b0);
        run_op(32, 3'd5, 32'h5678, 32'h0, 1'b0);
        run_op(32, 3'd6, 32'hDEAD, 32'hBEEF, 1'b0);
        run_op(32, 3'd0, 32'h12345678, 32'h9ABCDEF0, 1'b1);
        run_op(8, 3'd1, 32'hFF, 32'hFF, 1'b0);
        run_op(8, 3'd2, 32'h80, 32'hFF, 1'b0);

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom; b = $urandom;
            r = $urandom_range(0, 7);
            if (r == 0) b = 0;
            else if (r == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            else if (r == 2) b = b & 32'hF;
            run_op(32, o, a, b, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            o = 3'($urandom_range(0, 5));
            a = $urandom & 32'hFF; b = $urandom & 32'hFF;
            if ($urandom_range(0, 4) == 0) b = 0;
            run_op(8, o, a, b, 1'b0);
        end

        // Reset in the middle of a multiply aborts it
        op = 3'd0; opa = 32'h7; opb = 32'h9; start32 = 1'b1;
        @(posedge clk); #1 start32 = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        m_hi32 = '0; m_lo32 = '0; m_hi8 = '0; m_lo8 = '0;
        chk("midrst_hi", hi32, 32'h0);
        chk("midrst_lo", lo32, 32'h0);
        chk("midrst_busy", busy32, 1'b0);
        nd = 0;
        repeat (40) begin @(posedge clk); #1; if (done32) nd++; end
        chk("midrst_no_done", nd, 0);
        run_op(32, 3'd3, 32'd1000, 32'd7, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
